// File: rtl/text_dump_tx.sv
// Walks the tile RAM row by row and streams each character into a UART TX FIFO.
// Define TEXT_DUMP_CRLF_EN to append CR/LF after every row; left undefined, the output is the raw character stream.
module text_dump_tx #(
  parameter int COLS  = 40,
  parameter int ROWS  = 60,
  parameter int COL_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [11:0] ram_addr,
  input  logic [6:0]  ram_data,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
`ifdef TEXT_DUMP_CRLF_EN
    CR,
    LF,
`endif
    FIN
  } state_t;

  state_t             state, state_nx;
  logic [5:0]         row, row_nx;
  logic [COL_W-1:0]   col, col_nx;
  logic               last_col, last_row, row_adv;
  logic [7:0]         sub_char;

  assign last_col = (col == COL_W'(COLS - 1));
  assign last_row = (row == 6'(ROWS - 1));

  // Control and DEL codes are not printable on a terminal
  assign sub_char = (ram_data < 7'h20 || ram_data == 7'h7F) ? 8'h2E : {1'b0, ram_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      col   <= col_nx;
    end
  end

  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    wr_uart  = 1'b0;
    wr_data  = 8'h00;
    row_adv  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          row_nx   = '0;
          col_nx   = '0;
          state_nx = FETCH;
        end
      end
      FETCH: state_nx = SEND;
      SEND: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          wr_data = sub_char;
          if (last_col) begin
            col_nx = '0;
`ifdef TEXT_DUMP_CRLF_EN
            state_nx = CR;
`else
            row_adv = 1'b1;
`endif
          end else begin
            col_nx   = col + 1'b1;
            state_nx = FETCH;
          end
        end
      end
`ifdef TEXT_DUMP_CRLF_EN
      CR: begin
        if (!tx_full) begin
          wr_uart  = 1'b1;
          wr_data  = 8'h0D;
          state_nx = LF;
        end
      end
      LF: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          wr_data = 8'h0A;
          row_adv = 1'b1;
        end
      end
`endif
      FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (row_adv) begin
      if (last_row) begin
        state_nx = FIN;
      end else begin
        row_nx   = row + 1'b1;
        state_nx = FETCH;
      end
    end

    // Abort wins over any write issued in the same cycle
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      wr_uart  = 1'b0;
      wr_data  = 8'h00;
    end
  end

  assign ram_addr = {row, 6'(col)};
  assign busy     = (state != IDLE);
  assign done     = (state == FIN) && !abort;

endmodule

// File: tb/tb_text_dump_tx.sv
// Directed bench for text_dump_tx: a RAM model feeds the DUT, expected bytes go into a
// scoreboard queue at each start, and every UART write is popped and compared.
module tb_text_dump_tx;
  localparam int COLS  = 40;
  localparam int ROWS  = 60;
  localparam int COL_W = 6;
`ifdef TEXT_DUMP_CRLF_EN
  localparam int NBYTES = ROWS * COLS + 2 * ROWS;
`else
  localparam int NBYTES = ROWS * COLS;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, tx_full;
  logic [11:0] ram_addr;
  logic [6:0]  ram_data;
  logic        wr_uart;
  logic [7:0]  wr_data;
  logic        busy, done;

  logic [6:0]  mem [0:4095];
  logic [7:0]  q [$];
  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;

  text_dump_tx #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ram_addr(ram_addr), .ram_data(ram_data), .tx_full(tx_full),
    .wr_uart(wr_uart), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_data <= mem[ram_addr];

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(logic [6:0] d);
    return (d < 7'h20 || d == 7'h7F) ? 8'h2E : {1'b0, d};
  endfunction

  task automatic push_dump();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        logic [5:0] r6, c6;
        r6 = 6'(r);
        c6 = 6'(c);
        q.push_back(exp_char(mem[{r6, c6}]));
      end
`ifdef TEXT_DUMP_CRLF_EN
      q.push_back(8'h0D);
      q.push_back(8'h0A);
`endif
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_uart) begin
        logic [7:0] e;
        wr_cnt++;
        chk("wr_while_full", tx_full, 0);
        chk("write_expected", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("byte", wr_data, e);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last_byte", q.size(), 0);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_wr(int n);
    for (int i = 0; i < 20000 && wr_cnt < n; i++) begin
      @(posedge clk); #1;
    end
    chk("wr_timeout", int'(wr_cnt >= n), 1);
  endtask

  task automatic run_to_done(bit rnd_full);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 30000 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      if (rnd_full) tx_full = 1'($urandom_range(0, 1));
    end
    tx_full = 1'b0;
    chk("done_seen", done_cnt, d0 + 1);
    chk("idle_after_done", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("done_once", done_cnt, d0 + 1);
  endtask

  initial begin
    int w0, d0, a0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_full = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 7'(8'h41 + (i % 64));
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_uart", wr_uart, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_ram_addr", ram_addr, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // Pattern 0x41+col over the full screen
    push_dump();
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("first_addr", ram_addr, 0);
    run_to_done(1'b0);
    chk("full_dump_writes", wr_cnt, NBYTES);

    // Random contents with the substitution corner cells at the top-left
    for (int i = 0; i < 4096; i++) mem[i] = 7'($urandom_range(0, 127));
    mem[0] = 7'h07; mem[1] = 7'h7F; mem[2] = 7'h20; mem[3] = 7'h7E;
    push_dump();
    chk("sub_07", q[0], 8'h2E);
    chk("sub_7F", q[1], 8'h2E);
    chk("keep_20", q[2], 8'h20);
    chk("keep_7E", q[3], 8'h7E);
    pulse_start();
    run_to_done(1'b0);

    // Backpressure: 20-cycle stall, then random tx_full to the end
    w0 = wr_cnt;
    push_dump();
    pulse_start();
    wait_wr(w0 + 3);
    tx_full = 1'b1;
    a0 = ram_addr;
    w0 = wr_cnt;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 0 || i == 19) chk("stall_addr", ram_addr, a0);
    end
    chk("stall_no_write", wr_cnt, w0);
    tx_full = 1'b0;
    @(posedge clk); #1;
    chk("stall_release_once", wr_cnt, w0 + 1);
    run_to_done(1'b1);

    // Abort after the 10th byte
    w0 = wr_cnt;
    d0 = done_cnt;
    push_dump();
    pulse_start();
    wait_wr(w0 + 10);
    abort = 1'b1;
    q.delete();
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    w0 = wr_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_write", wr_cnt, w0);
    chk("abort_no_done", done_cnt, d0);

    // Restart from {0,0}, then abort inside a SEND cycle with tx_full low
    push_dump();
    pulse_start();
    chk("restart_addr", ram_addr, 0);
    wait_wr(w0 + 5);
    @(posedge clk); #1;
    abort = 1'b1;
    q.delete();
    w0 = wr_cnt;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_suppress", wr_cnt, w0);
    chk("abort2_busy", busy, 0);

    // Full dump with a second start ignored while busy
    push_dump();
    pulse_start();
    wait_wr(w0 + 50);
    pulse_start();
    run_to_done(1'b0);

    // Asynchronous reset mid-row
    w0 = wr_cnt;
    push_dump();
    pulse_start();
    wait_wr(w0 + 45);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", ram_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_uart", wr_uart, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_done", done, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    w0 = wr_cnt;
    push_dump();
    pulse_start();
    chk("post_rst_addr", ram_addr, 0);
    wait_wr(w0 + 30);
    pulse_start();
    run_to_done(1'b0);
    chk("post_rst_writes", wr_cnt, w0 + NBYTES);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/text_dump_tx.md
TEXT_DUMP_TX -- requirements
Module: text_dump_tx

Interface
REQ-001 SHALL have parameter COLS, default 40, characters per text row.
REQ-002 SHALL have parameter ROWS, default 60, text rows per screen.
REQ-003 SHALL have parameter COL_W, default 6, column-index width; row-index width is also 6.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle tick requesting a full-screen dump.
REQ-007 SHALL have port abort  input  1  level, terminates an active dump.
REQ-008 SHALL have port ram_addr  output  12  tile-RAM read address {row[5:0],col[5:0]}.
REQ-009 SHALL have port ram_data  input  7  ASCII code from tile RAM, valid one cycle after ram_addr is sampled.
REQ-010 SHALL have port tx_full  input  1  UART transmit FIFO full.
REQ-011 SHALL have port wr_uart  output  1  one-cycle write strobe into the UART transmit FIFO.
REQ-012 SHALL have port wr_data  output  8  byte written with wr_uart.
REQ-013 SHALL have port busy  output  1  high while a dump is active.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a dump completes normally.

Function
REQ-015 SHALL implement the states IDLE, FETCH, SEND, CR, LF and FIN.
REQ-016 IDLE: start=1 and abort=0 SHALL clear row and col to 0 and move to FETCH; otherwise stay in IDLE.
REQ-017 FETCH SHALL last exactly one cycle with ram_addr={row,col}, then move to SEND.
REQ-018 SEND SHALL hold ram_addr constant and wait while tx_full=1.
REQ-019 When tx_full=0 in SEND, wr_uart SHALL be 1 for exactly that cycle, with wr_data={1'b0,ram_data}.
REQ-020 Substitution: ram_data below 0x20 or equal to 0x7F SHALL be sent as 0x2E ('.').
REQ-021 After a SEND write with col<COLS-1, col SHALL increment and the FSM SHALL return to FETCH.
REQ-022 After a SEND write with col=COLS-1, col SHALL wrap to 0 and the FSM SHALL go to CR (macro defined) or row-advance (macro undefined).
REQ-023 Row-advance: row<ROWS-1 SHALL increment row and go to FETCH; row=ROWS-1 SHALL go to FIN.
REQ-024 CR and LF SHALL each wait for tx_full=0, write 0x0D and 0x0A respectively for one cycle, then CR goes to LF and LF performs row-advance.
REQ-025 FIN SHALL assert done for one cycle, then return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 wr_uart SHALL never be 1 in a cycle where tx_full=1.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 abort=1 in any non-IDLE state SHALL, on the next edge, go to IDLE with no further wr_uart and no done pulse.
REQ-030 abort has priority over a wr_uart in the same cycle: the write SHALL be suppressed.
REQ-031 A full dump SHALL write exactly ROWS*COLS bytes, plus 2*ROWS bytes when the macro is defined.
REQ-032 Throughput with tx_full=0 SHALL be one character per 2 cycles.

Reset
REQ-033 rst_n=0 SHALL immediately force state IDLE, row=0, col=0, ram_addr=0, wr_uart=0, wr_data=0, busy=0, done=0, independent of clk.
REQ-034 Reset mid-dump SHALL discard progress; the first start after release SHALL begin at address {0,0}.

Configuration
REQ-035 Macro TEXT_DUMP_CRLF_EN defined SHALL compile in the CR and LF states, appending 0x0D,0x0A after every row.
REQ-036 Macro TEXT_DUMP_CRLF_EN undefined SHALL remove the CR and LF states; the output SHALL be a raw ROWS*COLS byte stream.

Verification
REQ-037 RAM filled with 0x41+col, tx_full=0, start pulse -> bytes 0x41..0x68 per row, done once after the last byte; busy rises the cycle after start.
REQ-038 With CRLF_EN, COLS=4, ROWS=2 -> exactly 12 writes: 4 chars, 0D, 0A, 4 chars, 0D, 0A.
REQ-039 tx_full held high 20 cycles during SEND -> no wr_uart in that window; same byte written once on release and ram_addr unchanged throughout.
REQ-040 RAM cells 0x07 and 0x7F -> 0x2E sent; 0x20 and 0x7E sent unchanged.
REQ-041 abort asserted after the 10th byte -> no further writes, done stays 0, busy=0 next cycle; a new start then resumes from {0,0}.
REQ-042 rst_n pulsed low mid-row and start re-issued during the dump -> outputs at reset values immediately; the next dump starts at address 0 and second starts while busy cause no restart.
